// File: rtl/program_loader_pkg.sv
// Shared types for the boot-time program loader: data widths and loader FSM states.
package program_loader_pkg;

  localparam int unsigned HALF_WORD = 16;
  localparam int unsigned WORD      = 32;

  typedef enum logic [3:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  function automatic logic accepts_bytes(input loader_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA_LO) ||
           (s == DATA_HI) || (s == CHECK);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Boot-time sequencer: packs a length-prefixed little-endian byte stream into halfwords for the
// instruction memory and holds the core in reset until loaded. Optional trailer check: PROG_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 512,
  parameter int unsigned ADDR_BASE = 0
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic                 byte_ready_o,
  output logic                 program_mem_write_en_o,
  output logic [HALF_WORD-1:0] instruction_o,
  output logic [WORD-1:0]      instruction_addr_o,
  output logic                 cpu_reset_o,
  output logic                 load_done_o,
  output logic                 load_error_o
);

  localparam int unsigned CW = $clog2(MEM_DEPTH) + 1;

  loader_state_t        state_q, state_d;
  logic [7:0]           len_lo_q, len_lo_d;
  logic [CW-1:0]        len_q, len_d;
  logic [CW-1:0]        count_q, count_d;
  logic [7:0]           lo_q, lo_d;
  logic [HALF_WORD-1:0] instr_q, instr_d;
  logic [WORD-1:0]      addr_q, addr_d;
  logic                 we_q, we_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
`ifdef PROG_CHECKSUM_EN
  logic [7:0]           sum_q, sum_d;
`endif

  logic                 ready;
  logic                 xfer;
  logic                 tail;
  logic [15:0]          len_full;
  logic [CW-1:0]        count_inc;

  assign ready     = accepts_bytes(state_q);
  assign xfer      = byte_valid_i && ready;
  assign len_full  = {byte_i, len_lo_q};
  assign count_inc = count_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    count_d     = count_q;
    lo_d        = lo_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = err_q;
`ifdef PROG_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    tail        = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        // The core is released one cycle after DONE is entered
        if (state_q == DONE) cpu_reset_d = 1'b0;
        if (start_i) begin
          state_d     = LEN_LO;
          done_d      = 1'b0;
          err_d       = 1'b0;
          cpu_reset_d = 1'b1;
`ifdef PROG_CHECKSUM_EN
          sum_d       = '0;
`endif
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_lo_d = byte_i;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          if (len_full == '0) begin
            tail = 1'b1;
          end else if (32'(len_full) > MEM_DEPTH) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end else begin
            len_d   = len_full[CW-1:0];
            count_d = '0;
            state_d = DATA_LO;
          end
        end
      end
      DATA_LO: begin
        if (xfer) begin
          lo_d    = byte_i;
`ifdef PROG_CHECKSUM_EN
          sum_d   = sum_q + byte_i;
`endif
          state_d = DATA_HI;
        end
      end
      DATA_HI: begin
        // Write-port outputs are registered so they are valid throughout WRITE
        if (xfer) begin
          instr_d = {byte_i, lo_q};
          addr_d  = WORD'(ADDR_BASE) + WORD'(count_q);
          we_d    = 1'b1;
`ifdef PROG_CHECKSUM_EN
          sum_d   = sum_q + byte_i;
`endif
          state_d = WRITE;
        end
      end
      WRITE: begin
        count_d = count_inc;
        if (count_inc == len_q) tail = 1'b1;
        else                    state_d = DATA_LO;
      end
`ifdef PROG_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          if (byte_i == sum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (tail) begin
`ifdef PROG_CHECKSUM_EN
      state_d = CHECK;
`else
      state_d = DONE;
      done_d  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      len_lo_q    <= '0;
      len_q       <= '0;
      count_q     <= '0;
      lo_q        <= '0;
      instr_q     <= '0;
      addr_q      <= WORD'(ADDR_BASE);
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PROG_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      count_q     <= count_d;
      lo_q        <= lo_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef PROG_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign byte_ready_o           = ready;
  assign program_mem_write_en_o = we_q;
  assign instruction_o          = instr_q;
  assign instruction_addr_o     = addr_q;
  assign cpu_reset_o            = cpu_reset_q;
  assign load_done_o            = done_q;
  assign load_error_o           = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and randomized images against a queue-based model.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned BASE  = 0;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 valid;
  logic [7:0]           bdata;
  logic                 ready;
  logic                 we;
  logic [HALF_WORD-1:0] instr;
  logic [WORD-1:0]      iaddr;
  logic                 cpu_rst;
  logic                 done;
  logic                 err;

  program_loader #(.MEM_DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
    .clk_i                  (clk),
    .reset_i                (rst),
    .start_i                (start),
    .byte_valid_i           (valid),
    .byte_i                 (bdata),
    .byte_ready_o           (ready),
    .program_mem_write_en_o (we),
    .instruction_o          (instr),
    .instruction_addr_o     (iaddr),
    .cpu_reset_o            (cpu_rst),
    .load_done_o            (done),
    .load_error_o           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;
  typedef logic [15:0] wq_t[$];

  int  checks = 0;
  int  errors = 0;
  wr_t obs_q[$];
  wr_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor: every strobe is logged and must coincide with ready low
  always @(negedge clk) begin
    if (we === 1'b1) begin
      obs_q.push_back('{addr: iaddr, data: instr});
      chk("ready_during_write", 32'(ready), 32'd0);
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned maxgap);
    int unsigned gaps;
    int unsigned n;
    gaps = (maxgap == 0) ? 0 : $urandom_range(maxgap, 0);
    repeat (gaps) begin
      valid = 1'b0;
      @(negedge clk);
    end
    valid = 1'b1;
    bdata = b;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("byte_accept_timeout", 32'(ready), 32'd1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_write_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
      chk({tag, "_data"}, 32'(obs_q[i].data), 32'(exp_q[i].data));
    end
  endtask

  task automatic load_image(input string tag, input logic [15:0] n, input wq_t words,
                            input int unsigned gap, input bit bad_sum);
    logic [7:0]  sum;
    bit          ok;
    int unsigned waited;
    sum = 8'h00;
    ok  = (32'(n) <= DEPTH);
    obs_q.delete();
    exp_q.delete();
    if (ok) begin
      for (int i = 0; i < words.size(); i++) begin
        exp_q.push_back('{addr: BASE + 32'(i), data: words[i]});
        sum = sum + words[i][7:0] + words[i][15:8];
      end
    end
`ifdef PROG_CHECKSUM_EN
    if (bad_sum) ok = 1'b0;
`endif
    pulse_start();
    chk({tag, "_cpu_reset_loading"}, 32'(cpu_rst), 32'd1);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    if (32'(n) <= DEPTH) begin
      foreach (words[i]) begin
        send_byte(words[i][7:0], gap);
        send_byte(words[i][15:8], gap);
      end
`ifdef PROG_CHECKSUM_EN
      send_byte(bad_sum ? sum + 8'd1 : sum, gap);
`endif
    end
    waited = 0;
    while (!(done === 1'b1 || err === 1'b1) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
`ifndef PROG_CHECKSUM_EN
    if (n == 16'd0) chk({tag, "_done_latency"}, waited, 32'd0);
`endif
    chk({tag, "_done"}, 32'(done), 32'(ok));
    chk({tag, "_error"}, 32'(err), 32'(!ok));
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_cpu_reset_after"}, 32'(cpu_rst), 32'(!ok));
    compare_writes(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},   32'(ready),   32'd0);
    chk({tag, "_we"},      32'(we),      32'd0);
    chk({tag, "_instr"},   32'(instr),   32'd0);
    chk({tag, "_addr"},    iaddr,        BASE);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_done"},    32'(done),    32'd0);
    chk({tag, "_err"},     32'(err),     32'd0);
  endtask

  initial begin
    wq_t w;
    int unsigned n;
    rst   = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    bdata = 8'h00;
    #12;
    check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    valid = 1'b1;
    @(negedge clk);
    chk("idle_not_ready", 32'(ready), 32'd0);
    valid = 1'b0;

    // Basic two-instruction image
    w = '{16'h1234, 16'h5678};
    load_image("basic", 16'd2, w, 0, 1'b0);
    chk("hold_instr", 32'(instr), 32'h5678);
    chk("hold_addr", iaddr, BASE + 32'd1);

    // Empty image
    w = {};
    load_image("empty", 16'd0, w, 0, 1'b0);

    // Oversized length, then bytes offered in ERROR must not be taken
    load_image("too_long", 16'h0201, w, 0, 1'b0);
    valid = 1'b1;
    @(negedge clk);
    chk("error_not_ready", 32'(ready), 32'd0);
    valid = 1'b0;
    load_image("len_513", 16'd513, w, 0, 1'b0);

    // Random data with random valid gaps
    for (int r = 0; r < 3; r++) begin
      w = {};
      for (int i = 0; i < 4; i++) w.push_back(16'($urandom));
      load_image("gaps", 16'd4, w, 5, 1'b0);
    end

    // Full-depth image
    w = {};
    for (int i = 0; i < DEPTH; i++) w.push_back(16'($urandom));
    load_image("full_depth", 16'(DEPTH), w, 0, 1'b0);

    // Asynchronous reset after the first of three writes
    obs_q.delete();
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(8'hcd, 0);
    send_byte(8'hab, 0);
    n = 0;
    while (obs_q.size() < 1 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abandon_write_count", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) chk("abandon_first_data", 32'(obs_q[0].data), 32'hABCD);
    w = '{16'($urandom), 16'($urandom), 16'($urandom)};
    load_image("after_reset", 16'd3, w, 2, 1'b0);

`ifdef PROG_CHECKSUM_EN
    w = '{16'h1234};
    load_image("sum_good", 16'd1, w, 0, 1'b0);
    load_image("sum_bad", 16'd1, w, 0, 1'b1);
    w = '{16'($urandom), 16'($urandom)};
    load_image("sum_reload", 16'd2, w, 1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
